// File: rtl/warp_regfile_pkg.sv
// Shared types, default sizes and width helpers for the SIMT warp register file.
package warp_regfile_pkg;

    typedef enum logic [0:0] {RF_CLEAR, RF_READY} rf_state_e;

    localparam int unsigned DEF_LANES  = 16;
    localparam int unsigned DEF_WARPS  = 16;
    localparam int unsigned DEF_REGS   = 32;
    localparam int unsigned DEF_DATA_W = 64;

    // Index width for n entries, never below one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rf_lane_bank.sv
// One SIMT lane of storage: ROWS x DATA_W, one write and two registered read ports
// with write-first bypass.
module rf_lane_bank #(
    parameter int unsigned ROWS   = 512,
    parameter int unsigned ROW_W  = 9,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ROW_W-1:0]  wrow,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re_0,
    input  logic [ROW_W-1:0]  rrow_0,
    input  logic              re_1,
    input  logic [ROW_W-1:0]  rrow_1,
    output logic [DATA_W-1:0] rdata_0,
    output logic [DATA_W-1:0] rdata_1
);

    logic [DATA_W-1:0] mem_q [ROWS];
    logic [DATA_W-1:0] rdata_0_d, rdata_0_q;
    logic [DATA_W-1:0] rdata_1_d, rdata_1_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wrow] <= wdata;
        end
    end

    // Reads issued in the same cycle as a write to the same row see the new data.
    always_comb begin
        rdata_0_d = '0;
        rdata_1_d = '0;
        if (re_0) begin
            rdata_0_d = (we && (wrow == rrow_0)) ? wdata : mem_q[rrow_0];
        end
        if (re_1) begin
            rdata_1_d = (we && (wrow == rrow_1)) ? wdata : mem_q[rrow_1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_0_q <= '0;
            rdata_1_q <= '0;
        end else begin
            rdata_0_q <= rdata_0_d;
            rdata_1_q <= rdata_1_d;
        end
    end

    assign rdata_0 = rdata_0_q;
    assign rdata_1 = rdata_1_q;

endmodule

// File: rtl/warp_regfile_param.sv
// SIMT register file top: clear sequencer, write muxing, valid pipeline and per-lane banks.
module warp_regfile_param
    import warp_regfile_pkg::*;
#(
    parameter int unsigned LANES    = DEF_LANES,
    parameter int unsigned WARPS    = DEF_WARPS,
    parameter int unsigned REGS     = DEF_REGS,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned WARP_W  = idx_w(WARPS),
    localparam int unsigned ADDR_W  = idx_w(REGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES-1:0]        read_en_0,
    input  logic [WARP_W-1:0]       rwarp_0,
    input  logic [ADDR_W-1:0]       raddr_0,
    input  logic [LANES-1:0]        read_en_1,
    input  logic [WARP_W-1:0]       rwarp_1,
    input  logic [ADDR_W-1:0]       raddr_1,
    input  logic [LANES-1:0]        write_en,
    input  logic [WARP_W-1:0]       wwarp,
    input  logic [ADDR_W-1:0]       waddr,
    input  logic [LANES*DATA_W-1:0] wdata,
    output logic [LANES*DATA_W-1:0] rdata_0,
    output logic [LANES-1:0]        rvalid_0,
    output logic [LANES*DATA_W-1:0] rdata_1,
    output logic [LANES-1:0]        rvalid_1,
    output logic                    init_busy
);

    localparam int unsigned ROWS  = WARPS * REGS;
    localparam int unsigned ROW_W = idx_w(ROWS);
    localparam int unsigned CNT_W = WARP_W + ADDR_W + 1;

    rf_state_e          state_d, state_q;
    logic [CNT_W-1:0]   cnt_d, cnt_q;
    logic               busy_d, busy_q;
    logic [LANES-1:0]   rvalid_0_d, rvalid_0_q;
    logic [LANES-1:0]   rvalid_1_d, rvalid_1_q;

    logic [ROW_W-1:0]   rrow_0, rrow_1, wrow_user, bank_wrow;
    logic               ok_0, ok_1, ok_w, clearing;

    always_comb begin
        rrow_0    = ROW_W'(rwarp_0) * ROW_W'(REGS) + ROW_W'(raddr_0);
        rrow_1    = ROW_W'(rwarp_1) * ROW_W'(REGS) + ROW_W'(raddr_1);
        wrow_user = ROW_W'(wwarp) * ROW_W'(REGS) + ROW_W'(waddr);
        // Out-of-range indices and the hard-wired zero register never touch storage.
        ok_0 = (32'(rwarp_0) < WARPS) && (32'(raddr_0) < REGS) && !(ZERO_REG && raddr_0 == '0);
        ok_1 = (32'(rwarp_1) < WARPS) && (32'(raddr_1) < REGS) && !(ZERO_REG && raddr_1 == '0);
        ok_w = (32'(wwarp) < WARPS) && (32'(waddr) < REGS) && !(ZERO_REG && waddr == '0);
        clearing  = (state_q == RF_CLEAR) && !rst;
        bank_wrow = clearing ? cnt_q[ROW_W-1:0] : wrow_user;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        rvalid_0_d = busy_q ? '0 : read_en_0;
        rvalid_1_d = busy_q ? '0 : read_en_1;
        if (state_q == RF_CLEAR) begin
            if (cnt_q == CNT_W'(ROWS - 1)) begin
                state_d = RF_READY;
                busy_d  = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RF_CLEAR;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            rvalid_0_q <= '0;
            rvalid_1_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            rvalid_0_q <= rvalid_0_d;
            rvalid_1_q <= rvalid_1_d;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic              lane_we;
        logic [DATA_W-1:0] lane_wdata;

        assign lane_we    = clearing || (write_en[l] && ok_w && !busy_q && !rst);
        assign lane_wdata = clearing ? '0 : wdata[l*DATA_W +: DATA_W];

        rf_lane_bank #(
            .ROWS   (ROWS),
            .ROW_W  (ROW_W),
            .DATA_W (DATA_W)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .we      (lane_we),
            .wrow    (bank_wrow),
            .wdata   (lane_wdata),
            .re_0    (read_en_0[l] && ok_0 && !busy_q),
            .rrow_0  (rrow_0),
            .re_1    (read_en_1[l] && ok_1 && !busy_q),
            .rrow_1  (rrow_1),
            .rdata_0 (rdata_0[l*DATA_W +: DATA_W]),
            .rdata_1 (rdata_1[l*DATA_W +: DATA_W])
        );
    end

    assign rvalid_0  = rvalid_0_q;
    assign rvalid_1  = rvalid_1_q;
    assign init_busy = busy_q;

endmodule

// File: tb/tb_warp_regfile_param.sv
// Directed self-checking bench for warp_regfile_param at default sizes.
module tb_warp_regfile_param;

    localparam int unsigned LANES  = 16;
    localparam int unsigned WARPS  = 16;
    localparam int unsigned REGS   = 32;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned WARP_W = 4;
    localparam int unsigned ADDR_W = 5;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [LANES-1:0]        read_en_0, read_en_1, write_en;
    logic [WARP_W-1:0]       rwarp_0, rwarp_1, wwarp;
    logic [ADDR_W-1:0]       raddr_0, raddr_1, waddr;
    logic [LANES*DATA_W-1:0] wdata, rdata_0, rdata_1;
    logic [LANES-1:0]        rvalid_0, rvalid_1;
    logic                    init_busy;

    logic [LANES*DATA_W-1:0] exp0, exp1;
    int checks = 0;
    int errors = 0;
    int n;

    always #5 clk = ~clk;

    warp_regfile_param #(
        .LANES    (LANES),
        .WARPS    (WARPS),
        .REGS     (REGS),
        .DATA_W   (DATA_W),
        .ZERO_REG (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .read_en_0 (read_en_0),
        .rwarp_0   (rwarp_0),
        .raddr_0   (raddr_0),
        .read_en_1 (read_en_1),
        .rwarp_1   (rwarp_1),
        .raddr_1   (raddr_1),
        .write_en  (write_en),
        .wwarp     (wwarp),
        .waddr     (waddr),
        .wdata     (wdata),
        .rdata_0   (rdata_0),
        .rvalid_0  (rvalid_0),
        .rdata_1   (rdata_1),
        .rvalid_1  (rvalid_1),
        .init_busy (init_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        read_en_0 = '0; read_en_1 = '0; write_en = '0;
        rwarp_0 = '0; raddr_0 = '0; rwarp_1 = '0; raddr_1 = '0;
        wwarp = '0; waddr = '0; wdata = '0;
    endtask

    task automatic fill_wdata(input logic [DATA_W-1:0] v);
        for (int l = 0; l < LANES; l++) wdata[l*DATA_W +: DATA_W] = v;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        checks++;
        if (init_busy !== 1'b1 || rvalid_0 !== '0 || rdata_0 !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b rvalid_0=%h rdata_0 nonzero=%b (want 1,0000,0)",
                     init_busy, rvalid_0, |rdata_0);
        end
        n = 0;
        while (init_busy === 1'b1 && n < 600) begin
            tick();
            n++;
        end
        checks++;
        if (n != 512) begin
            errors++;
            $display("FAIL clear_length: busy cycles=%0d want 512", n);
        end
        read_en_0 = '1; rwarp_0 = 4'd3; raddr_0 = 5'd5;
        tick();
        idle();
        checks++;
        if (rdata_0 !== '0 || rvalid_0 !== 16'hFFFF) begin
            errors++;
            $display("FAIL post_clear_read: rvalid_0=%h want ffff, rdata_0 nonzero=%b want 0",
                     rvalid_0, |rdata_0);
        end
    endtask

    task automatic test_write_read();
        write_en = '1; wwarp = 4'd3; waddr = 5'd5;
        for (int l = 0; l < LANES; l++) begin
            wdata[l*DATA_W +: DATA_W] = 64'hA5A5_0000_0000_0000 + 64'(l);
            exp0[l*DATA_W +: DATA_W]  = 64'hA5A5_0000_0000_0000 + 64'(l);
        end
        tick();
        idle();
        checks++;
        if (rvalid_0 !== '0) begin
            errors++;
            $display("FAIL rvalid_drop: rvalid_0=%h want 0000", rvalid_0);
        end
        read_en_0 = '1; rwarp_0 = 4'd3; raddr_0 = 5'd5;
        tick();
        idle();
        checks++;
        if (rdata_0 !== exp0 || rvalid_0 !== 16'hFFFF) begin
            errors++;
            $display("FAIL write_read: rvalid_0=%h lane0=%h lane15=%h want ffff %h %h", rvalid_0,
                     rdata_0[0 +: 64], rdata_0[15*64 +: 64], exp0[0 +: 64], exp0[15*64 +: 64]);
        end
    endtask

    task automatic test_lane_mask();
        write_en = 16'h00F0; wwarp = 4'd3; waddr = 5'd5;
        fill_wdata(64'h1);
        tick();
        idle();
        read_en_0 = '1;       rwarp_0 = 4'd3; raddr_0 = 5'd5;
        read_en_1 = 16'h0F0F; rwarp_1 = 4'd3; raddr_1 = 5'd5;
        tick();
        idle();
        for (int l = 0; l < LANES; l++) begin
            exp0[l*DATA_W +: DATA_W] = (l >= 4 && l <= 7) ? 64'h1
                                                          : 64'hA5A5_0000_0000_0000 + 64'(l);
            exp1[l*DATA_W +: DATA_W] = ((l & 4) == 0) ? 64'hA5A5_0000_0000_0000 + 64'(l) : 64'h0;
        end
        checks++;
        if (rdata_0 !== exp0) begin
            errors++;
            $display("FAIL lane_mask_p0: lane3=%h lane4=%h want %h %h", rdata_0[3*64 +: 64],
                     rdata_0[4*64 +: 64], exp0[3*64 +: 64], exp0[4*64 +: 64]);
        end
        checks++;
        if (rdata_1 !== exp1 || rvalid_1 !== 16'h0F0F) begin
            errors++;
            $display("FAIL lane_mask_p1: rvalid_1=%h lane4=%h lane8=%h want 0f0f %h %h", rvalid_1,
                     rdata_1[4*64 +: 64], rdata_1[8*64 +: 64], exp1[4*64 +: 64], exp1[8*64 +: 64]);
        end
    endtask

    task automatic test_bypass_dual();
        write_en = '1; wwarp = 4'd7; waddr = 5'd9;
        fill_wdata(64'hDEAD);
        read_en_0 = '1; rwarp_0 = 4'd7; raddr_0 = 5'd9;
        read_en_1 = '1; rwarp_1 = 4'd7; raddr_1 = 5'd9;
        for (int l = 0; l < LANES; l++) exp0[l*DATA_W +: DATA_W] = 64'hDEAD;
        tick();
        idle();
        checks++;
        if (rdata_0 !== exp0 || rdata_1 !== exp0) begin
            errors++;
            $display("FAIL bypass_dual: p0 lane0=%h p1 lane0=%h want dead", rdata_0[0 +: 64],
                     rdata_1[0 +: 64]);
        end
        write_en = '1; wwarp = 4'd7; waddr = 5'd9;
        fill_wdata(64'hBEEF);
        read_en_0 = '1; rwarp_0 = 4'd7; raddr_0 = 5'd9;
        read_en_1 = '1; rwarp_1 = 4'd8; raddr_1 = 5'd9;
        for (int l = 0; l < LANES; l++) exp0[l*DATA_W +: DATA_W] = 64'hBEEF;
        tick();
        idle();
        checks++;
        if (rdata_0 !== exp0) begin
            errors++;
            $display("FAIL bypass_overwrite: lane0=%h want beef", rdata_0[0 +: 64]);
        end
        checks++;
        if (rdata_1 !== '0 || rvalid_1 !== 16'hFFFF) begin
            errors++;
            $display("FAIL other_warp: rvalid_1=%h lane0=%h want ffff 0", rvalid_1,
                     rdata_1[0 +: 64]);
        end
        // Partial-lane bypass: only written lanes take the new value.
        write_en = 16'h00FF; wwarp = 4'd7; waddr = 5'd9;
        fill_wdata(64'h1234);
        read_en_0 = '1; rwarp_0 = 4'd7; raddr_0 = 5'd9;
        for (int l = 0; l < LANES; l++) exp0[l*DATA_W +: DATA_W] = (l < 8) ? 64'h1234 : 64'hBEEF;
        tick();
        idle();
        checks++;
        if (rdata_0 !== exp0) begin
            errors++;
            $display("FAIL bypass_lane_mask: lane7=%h lane8=%h want 1234 beef",
                     rdata_0[7*64 +: 64], rdata_0[8*64 +: 64]);
        end
    endtask

    task automatic test_zero_reg();
        write_en = '1; wwarp = 4'd2; waddr = 5'd0;
        fill_wdata(64'hFFFF);
        tick();
        idle();
        read_en_0 = '1; rwarp_0 = 4'd2; raddr_0 = 5'd0;
        tick();
        idle();
        checks++;
        if (rdata_0 !== '0 || rvalid_0 !== 16'hFFFF) begin
            errors++;
            $display("FAIL zero_reg_read: rvalid_0=%h lane0=%h want ffff 0", rvalid_0,
                     rdata_0[0 +: 64]);
        end
        write_en = '1; wwarp = 4'd2; waddr = 5'd0;
        fill_wdata(64'hFFFF);
        read_en_1 = '1; rwarp_1 = 4'd2; raddr_1 = 5'd0;
        tick();
        idle();
        checks++;
        if (rdata_1 !== '0 || rvalid_1 !== 16'hFFFF) begin
            errors++;
            $display("FAIL zero_reg_bypass: rvalid_1=%h lane0=%h want ffff 0", rvalid_1,
                     rdata_1[0 +: 64]);
        end
    endtask

    task automatic test_mid_clear();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (100) tick();
        checks++;
        if (init_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_mid_clear: init_busy=%b want 1", init_busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n = 0;
        while (init_busy === 1'b1 && n < 600) begin
            if (n == 400) begin
                write_en = '1; wwarp = 4'd0; waddr = 5'd1;
                fill_wdata(64'h77);
                read_en_0 = '1; rwarp_0 = 4'd3; raddr_0 = 5'd5;
            end else if (n == 401) begin
                idle();
                checks++;
                if (rvalid_0 !== '0) begin
                    errors++;
                    $display("FAIL busy_read_valid: rvalid_0=%h want 0000", rvalid_0);
                end
            end
            tick();
            n++;
        end
        checks++;
        if (n != 512) begin
            errors++;
            $display("FAIL restart_clear_length: busy cycles=%0d want 512", n);
        end
        read_en_0 = '1; rwarp_0 = 4'd0; raddr_0 = 5'd1;
        read_en_1 = '1; rwarp_1 = 4'd3; raddr_1 = 5'd5;
        tick();
        idle();
        checks++;
        if (rdata_0 !== '0 || rdata_1 !== '0 || rvalid_0 !== 16'hFFFF) begin
            errors++;
            $display("FAIL busy_write_dropped: p0 lane0=%h p1 lane0=%h rvalid_0=%h want 0 0 ffff",
                     rdata_0[0 +: 64], rdata_1[0 +: 64], rvalid_0);
        end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        exp0 = '0;
        exp1 = '0;
        test_reset();
        test_write_read();
        test_lane_mask();
        test_bypass_dual();
        test_zero_reg();
        test_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
